// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO feeding a UART transmitter. CPU stores push bytes
//             into a DEPTH-entry circular buffer; a small feeder FSM drains
//             it one byte per frame over the start/data/busy handshake.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             wr_en_i, wr_data_i  - push strobe and byte
//             full_o, empty_o     - occupancy flags decoded from count_o
//             count_o             - occupancy 0..DEPTH
//             overflow_o          - sticky "push dropped while full" flag
//             ovf_clr_i           - synchronous clear of overflow_o
//             tx_start_o          - one-cycle start pulse to transmitter
//             tx_data_o           - byte presented to transmitter
//             tx_busy_i           - transmitter busy flag
//  Config   : `define UART_TX_FIFO_OVF_EN builds the sticky overflow flag;
//             otherwise overflow_o is tied low and ovf_clr_i is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  input  logic          ovf_clr_i,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_busy_i
);

  localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    UNUSED  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          push;
  logic          pop;
  logic          drop;

  state_e        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;

  assign full_o  = (count_q == c_FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Acceptance is decided on the flag at the sampling edge only: a pop in
  // the same cycle does not free a slot for a push that finds the FIFO full.
  assign push = wr_en_i && !full_o;
  assign drop = wr_en_i && full_o;

  // The byte is latched into tx_data when the start is issued; the entry is
  // retired in the following cycle, while the start pulse is on the wire.
  // This gives count -> 0 two edges after the start decision.
  assign pop  = tx_start_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Feeder FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (!empty_o && !tx_busy_i) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

  // --------------------------------------------------------------------------
  // Overflow flag
  // --------------------------------------------------------------------------
`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_q, overflow_d;

  // A drop in the same cycle as a clear wins, so no drop is ever lost.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr_i ^ drop;
  assign overflow_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo: a cycle table for the
//             single-byte latency, directed corner sequences and a random
//             run against a queue-based reference model with a simple
//             transmitter busy model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NEVER = 32'h3fff_ffff;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ovf_clr;
  logic          tx_busy;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow),
    .ovf_clr_i  (ovf_clr),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .tx_busy_i  (tx_busy)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  logic [7:0] q_m[$];        // accepted, not yet retired bytes
  bit         ovf_m;
  logic [7:0] txd_m;         // byte expected on tx_data
  int         ready_from;    // first cycle the feeder may decide a start
  bit         waiting;       // a start was issued, handshake not complete
  bit         seen_high;
  int         prev_size;
  bit         prev_busy;

  // Transmitter model
  int         bm_left;
  int         frame_len;
  bit         hold_busy;
  logic [7:0] sent[$];

  typedef struct {
    bit         we;
    logic [7:0] wd;
    int         exp_count;
    bit         exp_start;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic update_busy();
    if (bm_left > 0) begin
      tx_busy = 1'b1;
      bm_left--;
    end else begin
      tx_busy = hold_busy;
    end
  endtask

  // Called at 1 time unit after a rising edge: check the current cycle,
  // drive this cycle's inputs, advance the model across the next edge.
  task automatic step(input bit we, input logic [7:0] wd, input bit clr);
    bit exp_start;
    bit push_ok;
    exp_start = (cyc - 1 >= ready_from) && (prev_size > 0) && !prev_busy;
    chk("count",    32'(count),    32'(q_m.size()));
    chk("full",     32'(full),     32'(q_m.size() == DEPTH));
    chk("empty",    32'(empty),    32'(q_m.size() == 0));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("tx_start", 32'(tx_start), 32'(exp_start));
    if (exp_start && q_m.size() > 0) txd_m = q_m[0];
    chk("tx_data",  32'(tx_data),  32'(txd_m));
    if (tx_start) sent.push_back(tx_data);

    update_busy();
    if (tx_start) begin
      bm_left    = frame_len;
      waiting    = 1'b1;
      seen_high  = tx_busy;
      ready_from = NEVER;
    end else if (waiting) begin
      if (seen_high && !tx_busy) begin
        ready_from = cyc + 1;
        waiting    = 1'b0;
      end else if (tx_busy) begin
        seen_high = 1'b1;
      end
    end

    wr_en   = we;
    wr_data = wd;
    ovf_clr = clr;

    prev_size = q_m.size();
    prev_busy = tx_busy;
    push_ok   = we && (q_m.size() < DEPTH);
    if (exp_start && q_m.size() > 0) void'(q_m.pop_front());
    if (push_ok) q_m.push_back(wd);
    if (OVF_EN) begin
      if (we && !push_ok) ovf_m = 1'b1;
      else if (clr)       ovf_m = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    #1;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    update_busy();
    q_m.delete();
    ovf_m     = 1'b0;
    txd_m     = 8'h00;
    waiting   = 1'b0;
    seen_high = 1'b0;
    prev_size = 0;
    prev_busy = tx_busy;
    @(posedge clk);
    #1;
    cyc++;
    rst_n      = 1'b1;
    ready_from = cyc;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_m.size() != 0 || bm_left != 0 || tx_busy) && n < budget) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    step(1'b0, 8'h00, 1'b0);
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout cyc=%0d actual=%0d cycles expected<%0d", cyc, n, budget);
    end
  endtask

  task automatic wait_start(input string name, input int budget);
    int n;
    n = 0;
    while (!tx_start && n < budget) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    n_tests++;
    if (!tx_start) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=no_start expected=tx_start within %0d", name, cyc, budget);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    ovf_clr   = 1'b0;
    tx_busy   = 1'b0;
    bm_left   = 0;
    hold_busy = 1'b0;
    frame_len = 3;
    @(posedge clk);
    #1;
    do_reset();
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // ---- single byte, then a second byte queued mid-frame (frame_len 3) ----
    tbl[0]  = '{1'b1, 8'hA5, 0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1, 1'b1, 8'hA5};
    tbl[3]  = '{1'b1, 8'h5A, 0, 1'b0, 8'hA5};
    tbl[4]  = '{1'b0, 8'h00, 1, 1'b0, 8'hA5};
    tbl[5]  = '{1'b0, 8'h00, 1, 1'b0, 8'hA5};
    tbl[6]  = '{1'b0, 8'h00, 1, 1'b0, 8'hA5};
    tbl[7]  = '{1'b0, 8'h00, 1, 1'b0, 8'hA5};
    tbl[8]  = '{1'b0, 8'h00, 1, 1'b1, 8'h5A};
    tbl[9]  = '{1'b0, 8'h00, 0, 1'b0, 8'h5A};
    tbl[10] = '{1'b0, 8'h00, 0, 1'b0, 8'h5A};
    for (int i = 0; i < 11; i++) begin
      chk("tbl_count",    32'(count),    32'(tbl[i].exp_count));
      chk("tbl_tx_start", 32'(tx_start), 32'(tbl[i].exp_start));
      chk("tbl_tx_data",  32'(tx_data),  32'(tbl[i].exp_data));
      step(tbl[i].we, tbl[i].wd, 1'b0);
    end
    drain(100);

    // ---- burst to full, overflow handling, in-order drain ----
    hold_busy = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("burst_full",  32'(full),  32'd1);
    chk("burst_count", 32'(count), 32'd16);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_count",   32'(count),    32'd16);
    chk("ovf_set",     32'(overflow), 32'(OVF_EN));
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr",     32'(overflow), 32'd0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFE, 1'b1);
    chk("ovf_set_beats_clr", 32'(overflow), 32'(OVF_EN));
    step(1'b0, 8'h00, 1'b1);
    sent.delete();
    hold_busy = 1'b0;
    frame_len = 4;
    drain(400);
    chk("burst_sent_n", 32'(sent.size()), 32'd16);
    for (int i = 0; i < sent.size() && i < 16; i++) chk("burst_order", 32'(sent[i]), 32'(i + 1));

    // ---- push in the same cycle as the pop ----
    hold_busy = 1'b1;
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    hold_busy = 1'b0;
    wait_start("sim_first_start", 20);
    chk("sim_count_before", 32'(count),   32'd1);
    chk("sim_first_data",   32'(tx_data), 32'h11);
    step(1'b1, 8'h3C, 1'b0);
    chk("sim_count_after",  32'(count),   32'd1);
    step(1'b0, 8'h00, 1'b0);
    wait_start("sim_second_start", 40);
    chk("sim_next_data",    32'(tx_data), 32'h3C);
    drain(100);

    // ---- reset in the middle of a frame with 5 bytes queued ----
    frame_len = 40;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_busy",  32'(bm_left > 0), 32'd1);
    do_reset();
    step(1'b1, 8'h77, 1'b0);
    sent.delete();
    frame_len = 3;
    wait_start("post_rst_start", 80);
    chk("post_rst_no_early_start", 32'(bm_left), 32'd0);
    chk("post_rst_data", 32'(tx_data), 32'h77);
    drain(100);

    // ---- 40 bytes through the buffer, across pointer wrap ----
    frame_len = 2;
    sent.delete();
    begin
      int nb;
      int guard;
      nb    = 0;
      guard = 0;
      while (nb < 40 && guard < 2000) begin
        if (q_m.size() < DEPTH) begin
          step(1'b1, 8'(nb), 1'b0);
          nb++;
        end else begin
          step(1'b0, 8'h00, 1'b0);
        end
        guard++;
      end
    end
    drain(400);
    chk("wrap_sent_n", 32'(sent.size()), 32'd40);
    for (int i = 0; i < sent.size() && i < 40; i++) chk("wrap_order", 32'(sent[i]), 32'(i));
    chk("wrap_empty", 32'(empty), 32'd1);

    // ---- randomized traffic against the model ----
    begin
      int rate;
      rate = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 150 == 0) begin
          rate      = int'($urandom_range(5, 95));
          frame_len = int'($urandom_range(1, 8));
          hold_busy = ($urandom_range(0, 5) == 0);
        end
        if (c == 1500) do_reset();
        step(($urandom_range(0, 99) < rate), 8'($urandom), ($urandom_range(0, 15) == 0));
      end
    end
    hold_busy = 1'b0;
    drain(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
